// File: rtl/window_max.sv
// rtl/window_max.sv - windowed maximum of shifted sums, CAPH-style FIFO actor
module window_max #(
    parameter int WINDOW = 4,
    parameter int SHIFT  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in0_empty,
    input  logic [15:0] in0,
    output logic        in0_rd,
    input  logic        out0_full,
    output logic [15:0] out0,
    output logic        out0_wr
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam logic [7:0] LAST = 8'(WINDOW - 1);

    state_t      state, state_next;
    logic [7:0]  count, count_next;
    logic [15:0] p_max, p_max_next;
    logic [15:0] mean;

    assign mean = in0 >> SHIFT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
            count <= 8'd0;
            p_max <= 16'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            p_max <= p_max_next;
        end
    end

    // Strobes are ANDed with reset so nothing moves while reset is held low.
    always_comb begin
        state_next = state;
        count_next = count;
        p_max_next = p_max;
        in0_rd     = 1'b0;
        out0_wr    = 1'b0;
        out0       = 16'h0000;
        case (state)
            COLLECT: begin
                if (!in0_empty) begin
                    in0_rd = reset;
                    if (count == 8'd0) begin
                        p_max_next = mean;
                    end else if (mean > p_max) begin
                        p_max_next = mean;
                    end
                    if (count == LAST) begin
                        count_next = 8'd0;
                        state_next = EMIT;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end
            end
            EMIT: begin
                if (!out0_full) begin
                    out0_wr    = reset;
                    out0       = reset ? p_max : 16'h0000;
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_window_max.sv
// tb/tb_window_max.sv - self-checking bench for window_max with a window-max reference model
module tb_window_max;

    localparam int W = 4;
    localparam int S = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_empty, a_rd, a_full, a_wr;
    logic [15:0] a_in, a_out;
    logic        b_empty, b_rd, b_full, b_wr;
    logic [15:0] b_in, b_out;

    always #5 clock = ~clock;

    window_max #(.WINDOW(W), .SHIFT(S)) dut_a (
        .clock(clock), .reset(reset),
        .in0_empty(a_empty), .in0(a_in), .in0_rd(a_rd),
        .out0_full(a_full), .out0(a_out), .out0_wr(a_wr)
    );

    window_max #(.WINDOW(2), .SHIFT(0)) dut_b (
        .clock(clock), .reset(reset),
        .in0_empty(b_empty), .in0(b_in), .in0_rd(b_rd),
        .out0_full(b_full), .out0(b_out), .out0_wr(b_wr)
    );

    int passed = 0;
    int total  = 0;

    logic [15:0] src[$];
    logic [15:0] win[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    logic [15:0] bsrc[$];
    logic [15:0] bgot[$];
    int gap_len = 0, gap_cnt = 0;
    int cycle = 0, first_read_cycle = -1, last_read_cycle = 0, last_write_cycle = 0;
    int reads = 0, writes = 0;
    bit rand_mode = 0;
    logic obs_rd, obs_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic logic [15:0] win_max();
        logic [15:0] m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        return m;
    endfunction

    // Reference: group consumed tokens by WINDOW, emit max of the truncated means.
    task automatic model_pop(input logic [15:0] tok);
        win.push_back(tok >> S);
        if (win.size() == W) begin
            exp_q.push_back(win_max());
            win.delete();
        end
    endtask

    task automatic apply_inputs();
        if (rand_mode) a_full = ($urandom_range(0, 3) == 0);
        a_empty = (src.size() == 0) || (gap_cnt > 0);
        a_in    = a_empty ? 16'($urandom) : src[0];
    endtask

    task automatic tick();
        @(negedge clock);
        obs_rd = a_rd;
        obs_wr = a_wr;
        check("protocol", {a_rd & a_empty, a_rd & a_wr, a_wr & a_full, !a_wr && (a_out != 16'h0)}, 0);
        if (a_rd) begin
            reads++;
            if (first_read_cycle < 0) first_read_cycle = cycle;
            last_read_cycle = cycle;
            model_pop(src.pop_front());
            gap_cnt = rand_mode ? int'($urandom_range(0, 2)) : gap_len;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        if (a_wr) begin
            writes++;
            last_write_cycle = cycle;
            got.push_back(a_out);
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out0_vs_model", a_out, exp_q.pop_front());
        end
        @(posedge clock);
        #1;
        cycle++;
        apply_inputs();
    endtask

    task automatic run_writes(input int target, input int budget, input string tag);
        int n = 0;
        while (writes < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, writes >= target, 1);
    endtask

    task automatic apply_b();
        b_empty = (bsrc.size() == 0);
        b_in    = b_empty ? 16'($urandom) : bsrc[0];
    endtask

    initial begin
        int r0, w0, n, b_reads;

        // Reset with data present: strobes must stay gated.
        reset = 1'b0; a_full = 1'b0; a_empty = 1'b0; a_in = 16'd800;
        b_full = 1'b0; b_empty = 1'b0; b_in = 16'd5;
        #12;
        check("reset_outputs_a", {a_rd, a_wr, a_out}, 0);
        check("reset_outputs_b", {b_rd, b_wr, b_out}, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        b_empty = 1'b1;
        apply_inputs();
        repeat (2) tick();
        check("idle_after_reset", {obs_rd, obs_wr}, 0);

        // Basic window and latency.
        src = '{16'd800, 16'd1600, 16'd80, 16'd8};
        apply_inputs();
        first_read_cycle = -1;
        run_writes(1, 40, "basic_timeout");
        check("basic_value", got[got.size()-1], 200);
        check("basic_consecutive_reads", last_read_cycle - first_read_cycle, 3);
        check("basic_latency", last_write_cycle - first_read_cycle, W);

        // Max, truncation, then reload by first token of next window.
        src = '{16'hFFFF, 16'd7, 16'd0, 16'd15, 16'd8, 16'd8, 16'd8, 16'd8};
        apply_inputs();
        run_writes(3, 60, "trunc_timeout");
        check("max_trunc_value", got[got.size()-2], 16'h1FFF);
        check("reload_value", got[got.size()-1], 1);

        // Backpressure for 10 cycles with a non-empty FIFO.
        src = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd800};
        a_full = 1'b1;
        apply_inputs();
        r0 = reads; n = 0;
        while (reads < r0 + 4 && n < 40) begin tick(); n++; end
        check("bp_collect_timeout", reads - r0, 4);
        w0 = writes;
        repeat (10) begin
            tick();
            check("bp_hold", {obs_rd, obs_wr}, 0);
        end
        a_full = 1'b0;
        tick();
        check("bp_release_write", {obs_rd, obs_wr}, 2'b01);
        check("bp_value", got[got.size()-1], 50);
        tick();
        check("bp_read_resumes", obs_rd, 1);
        run_writes(w0 + 2, 40, "bp_second_timeout");
        check("bp_second_value", got[got.size()-1], 100);

        // Empty gaps between tokens.
        gap_len = 3;
        src = '{16'd800, 16'd1600, 16'd80, 16'd8};
        apply_inputs();
        run_writes(writes + 1, 80, "gap_timeout");
        check("gap_value", got[got.size()-1], 200);
        gap_len = 0;

        // Asynchronous reset mid-window.
        src = '{16'd1000, 16'd2000, 16'd3000, 16'd4000};
        apply_inputs();
        r0 = reads; n = 0;
        while (reads < r0 + 2 && n < 40) begin tick(); n++; end
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {a_rd, a_wr, a_out}, 0);
        win.delete();
        src.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle++;
        apply_inputs();
        w0 = writes;
        repeat (6) tick();
        check("no_partial_write", writes, w0);
        src = '{16'd40, 16'd80, 16'd120, 16'd160};
        apply_inputs();
        run_writes(w0 + 1, 40, "post_reset_timeout");
        check("post_reset_value", got[got.size()-1], 20);

        // Randomized tokens, gaps and backpressure against the model.
        rand_mode = 1;
        repeat (48) src.push_back(16'($urandom));
        apply_inputs();
        n = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && n < 3000) begin tick(); n++; end
        check("random_drain", src.size() + exp_q.size(), 0);
        rand_mode = 0;
        a_full = 1'b0;

        // WINDOW=2, SHIFT=0 instance.
        bsrc = '{16'd5, 16'd9, 16'd9, 16'd3};
        apply_b();
        b_reads = 0;
        repeat (10) begin
            @(negedge clock);
            check("sweep_protocol", {b_rd & b_empty, b_rd & b_wr, !b_wr && (b_out != 16'h0)}, 0);
            if (b_rd) begin
                b_reads++;
                void'(bsrc.pop_front());
            end
            if (b_wr) begin
                check("sweep_reads_per_out", b_reads, 2);
                b_reads = 0;
                bgot.push_back(b_out);
            end
            @(posedge clock);
            #1;
            apply_b();
        end
        check("sweep_count", bgot.size(), 2);
        check("sweep_first", bgot.size() > 0 ? bgot[0] : 16'hDEAD, 9);
        check("sweep_second", bgot.size() > 1 ? bgot[1] : 16'hDEAD, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
